// File: rtl/turf_register_arbiter_if.sv
// turf_register_arbiter_if: requester handshake and register-bus signals of the arbiter
interface turf_register_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_en_i;
  logic [NREQ-1:0]    req_wr_i;
  logic [NREQ*28-1:0] req_adr_i;
  logic [NREQ*32-1:0] req_dat_i;
  logic [NREQ-1:0]    req_ack_o;
  logic               req_err_o;
  logic [31:0]        rdat_o;
  logic               en_o;
  logic               wr_o;
  logic [27:0]        adr_o;
  logic [31:0]        dat_o;
  logic [31:0]        dat_i;
  logic               ack_i;
  logic [15:0]        err_count_o;
  modport slave (
    input  req_en_i, req_wr_i, req_adr_i, req_dat_i, dat_i, ack_i,
    output req_ack_o, req_err_o, rdat_o, en_o, wr_o, adr_o, dat_o, err_count_o
  );
  modport master (
    output req_en_i, req_wr_i, req_adr_i, req_dat_i, dat_i, ack_i,
    input  req_ack_o, req_err_o, rdat_o, en_o, wr_o, adr_o, dat_o, err_count_o
  );
endinterface

// File: rtl/turf_register_arbiter.sv
// turf_register_arbiter: round-robin sharing of the TURF register bus with an ack timeout
module turf_register_arbiter #(
  parameter int          NREQ     = 2,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic clk,
  input logic rst,
  turf_register_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, pick;
  logic [7:0] cnt;
  logic found, tmo;
  assign found = |bus.req_en_i;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  // second loop overrides the first so requesters above the pointer take priority
  always_comb begin
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) if (bus.req_en_i[i] && i <= int'(ptr)) pick = PW'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (bus.req_en_i[i] && i > int'(ptr)) pick = PW'(i);
  end
  always_comb begin
    state_nx = state == IDLE  ? (found ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? ((bus.ack_i || tmo) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= PW'(NREQ - 1);
      cnt             <= 8'd0;
      bus.en_o        <= 1'b0;
      bus.wr_o        <= 1'b0;
      bus.adr_o       <= 28'd0;
      bus.dat_o       <= 32'd0;
      bus.rdat_o      <= 32'd0;
      bus.req_ack_o   <= '0;
      bus.req_err_o   <= 1'b0;
      bus.err_count_o <= 16'd0;
    end else begin
      bus.en_o      <= state == IDLE && found;
      bus.req_ack_o <= (state == WAIT && (bus.ack_i || tmo)) ? NREQ'(1) << ptr : '0;
      bus.req_err_o <= state == WAIT && !bus.ack_i && tmo;
      cnt           <= state == WAIT ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && found) begin
        ptr       <= pick;
        bus.wr_o  <= bus.req_wr_i[pick];
        bus.adr_o <= bus.req_adr_i[28*pick +: 28];
        bus.dat_o <= bus.req_dat_i[32*pick +: 32];
      end
      if (state == WAIT && bus.ack_i) bus.rdat_o <= bus.dat_i;
      else if (state == WAIT && tmo) begin
        bus.rdat_o <= ERR_DATA;
        if (bus.err_count_o != 16'hFFFF) bus.err_count_o <= bus.err_count_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_turf_register_arbiter.sv
// tb_turf_register_arbiter: directed checks of grant order, latency, timeout and reset
module tb_turf_register_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  turf_register_arbiter_if #(.NREQ(2)) bus();
  turf_register_arbiter #(.NREQ(2), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [31:0] mem [16];
  int ack_lat = 1;
  int age = 100;
  int ncyc = 0;
  int checks = 0;
  int errors = 0;
  assign bus.dat_i = mem[bus.adr_o[3:0]];
  // slave model: ack_i lands ack_lat cycles after en_o (never when ack_lat is 0)
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (rst) mem[2] <= 32'h12345678;
    if (bus.en_o) begin
      age <= 1;
      bus.ack_i <= ack_lat == 1;
      if (bus.wr_o) mem[bus.adr_o[3:0]] <= bus.dat_o;
    end else begin
      age <= age + 1;
      bus.ack_i <= ack_lat != 0 && age + 1 == ack_lat;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ack(output logic [1:0] a);
    int n = 0;
    while (bus.req_ack_o == 2'b00 && n < 40) begin
      cyc(1);
      n++;
    end
    if (n >= 40) chk("ack_wait_expired", 32'(n), 32'd0);
    a = bus.req_ack_o;
  endtask
  initial begin
    logic [1:0] a;
    logic [1:0] exp;
    int n;
    int last_en;
    bus.req_en_i  = 2'b00;
    bus.req_wr_i  = 2'b00;
    bus.req_adr_i = '0;
    bus.req_dat_i = '0;
    cyc(2);
    chk("rst_en", bus.en_o, 1'b0);
    chk("rst_ack", bus.req_ack_o, 2'b00);
    chk("rst_err", bus.req_err_o, 1'b0);
    chk("rst_rdat", bus.rdat_o, 32'd0);
    chk("rst_adr", bus.adr_o, 28'd0);
    chk("rst_errcnt", bus.err_count_o, 16'd0);
    rst = 1'b0;
    cyc(1);
    // single read, one-cycle-ack slave
    bus.req_adr_i[27:0] = 28'd2;
    bus.req_en_i = 2'b01;
    cyc(1);
    chk("rd_en", bus.en_o, 1'b1);
    chk("rd_adr", bus.adr_o, 28'd2);
    chk("rd_wr", bus.wr_o, 1'b0);
    cyc(1);
    chk("rd_en_pulse", bus.en_o, 1'b0);
    chk("rd_ack_early", bus.req_ack_o, 2'b00);
    cyc(1);
    chk("rd_ack", bus.req_ack_o, 2'b01);
    chk("rd_rdat", bus.rdat_o, 32'h12345678);
    chk("rd_err", bus.req_err_o, 1'b0);
    bus.req_en_i = 2'b00;
    cyc(1);
    chk("rd_ack_pulse", bus.req_ack_o, 2'b00);
    // contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.req_adr_i = {28'd3, 28'd2};
    bus.req_en_i = 2'b11;
    last_en = 0;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (!bus.en_o && n < 20) begin
        cyc(1);
        n++;
      end
      chk("ct_en_seen", bus.en_o, 1'b1);
      if (t > 0) chk("ct_en_gap", 32'(ncyc - last_en >= 4), 32'd1);
      last_en = ncyc;
      chk("ct_grant_adr", bus.adr_o, exp == 2'b01 ? 28'd2 : 28'd3);
      wait_ack(a);
      chk("ct_ack", a, exp);
      bus.req_en_i = 2'b11 & ~exp;
      cyc(1);
      chk("ct_ack_pulse", bus.req_ack_o, 2'b00);
      bus.req_en_i = (t == 3) ? 2'b00 : 2'b11;
    end
    cyc(2);
    // timeout: slave never acks
    ack_lat = 0;
    bus.req_adr_i = {28'd2, 28'd2};
    bus.req_en_i = 2'b01;
    cyc(1);
    chk("to_en", bus.en_o, 1'b1);
    cyc(16);
    chk("to_ack_early", bus.req_ack_o, 2'b00);
    cyc(1);
    chk("to_ack", bus.req_ack_o, 2'b01);
    chk("to_err", bus.req_err_o, 1'b1);
    chk("to_rdat", bus.rdat_o, 32'hDEADBEEF);
    chk("to_errcnt", bus.err_count_o, 16'd1);
    bus.req_en_i = 2'b00;
    cyc(1);
    chk("to_err_clear", bus.req_err_o, 1'b0);
    ack_lat = 1;
    bus.req_en_i = 2'b10;
    cyc(3);
    chk("after_to_ack", bus.req_ack_o, 2'b10);
    chk("after_to_err", bus.req_err_o, 1'b0);
    chk("after_to_rdat", bus.rdat_o, 32'h12345678);
    bus.req_en_i = 2'b00;
    cyc(1);
    // ack on the final timeout cycle wins
    ack_lat = 16;
    bus.req_en_i = 2'b01;
    cyc(1);
    chk("co_en", bus.en_o, 1'b1);
    cyc(16);
    chk("co_ack_early", bus.req_ack_o, 2'b00);
    cyc(1);
    chk("co_ack", bus.req_ack_o, 2'b01);
    chk("co_err", bus.req_err_o, 1'b0);
    chk("co_rdat", bus.rdat_o, 32'h12345678);
    chk("co_errcnt", bus.err_count_o, 16'd1);
    bus.req_en_i = 2'b00;
    cyc(1);
    // write pass-through then read back
    ack_lat = 1;
    bus.req_wr_i = 2'b10;
    bus.req_dat_i = {32'hCAFEF00D, 32'h0};
    bus.req_en_i = 2'b10;
    cyc(1);
    chk("wr_en", bus.en_o, 1'b1);
    chk("wr_wr", bus.wr_o, 1'b1);
    chk("wr_adr", bus.adr_o, 28'd2);
    chk("wr_dat", bus.dat_o, 32'hCAFEF00D);
    cyc(1);
    chk("wr_wr_held", bus.wr_o, 1'b1);
    chk("wr_dat_held", bus.dat_o, 32'hCAFEF00D);
    chk("wr_adr_held", bus.adr_o, 28'd2);
    cyc(1);
    chk("wr_ack", bus.req_ack_o, 2'b10);
    bus.req_en_i = 2'b00;
    bus.req_wr_i = 2'b00;
    cyc(1);
    bus.req_en_i = 2'b01;
    cyc(3);
    chk("rb_ack", bus.req_ack_o, 2'b01);
    chk("rb_rdat", bus.rdat_o, 32'hCAFEF00D);
    bus.req_en_i = 2'b00;
    cyc(1);
    // asynchronous reset mid-WAIT
    ack_lat = 0;
    bus.req_en_i = 2'b01;
    cyc(1);
    chk("rw_en", bus.en_o, 1'b1);
    cyc(3);
    #1 rst = 1'b1;
    #1;
    chk("rw_en0", bus.en_o, 1'b0);
    chk("rw_ack0", bus.req_ack_o, 2'b00);
    chk("rw_rdat0", bus.rdat_o, 32'd0);
    chk("rw_adr0", bus.adr_o, 28'd0);
    chk("rw_errcnt0", bus.err_count_o, 16'd0);
    bus.req_en_i = 2'b00;
    cyc(2);
    chk("rw_no_ack", bus.req_ack_o, 2'b00);
    rst = 1'b0;
    ack_lat = 1;
    bus.req_adr_i = {28'd3, 28'd2};
    bus.req_en_i = 2'b11;
    cyc(1);
    chk("rw_regrant_en", bus.en_o, 1'b1);
    chk("rw_regrant_adr", bus.adr_o, 28'd2);
    cyc(2);
    chk("rw_regrant_ack", bus.req_ack_o, 2'b01);
    bus.req_en_i = 2'b00;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/turf_register_arbiter.md
Name: turf_register_arbiter

Overview:
Shares the single TURF register-space bus (en/wr/adr/dat in, ack/dat out) between NREQ independent requesters, e.g. the host command path and local sequencers. Round-robin grant, one outstanding transaction at a time, with an ack timeout so a dead slave cannot hang the bus. Sits directly in front of the register core; requesters see a simple request/ack handshake plus an error flag.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
TIMEOUT, 16, WAIT-state cycles without ack_i before the transaction is aborted (legal 2..255)
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-high reset
req_en_i  input  NREQ  per-requester request; held high until its req_ack_o pulse, dropped the following cycle
req_wr_i  input  NREQ  per-requester write (1) / read (0)
req_adr_i  input  NREQ*28  per-requester address, requester k in bits [28k+27:28k]
req_dat_i  input  NREQ*32  per-requester write data, requester k in bits [32k+31:32k]
req_ack_o  output  NREQ  one-hot, one-cycle completion pulse to the granted requester
req_err_o  output  1  high with req_ack_o when the transaction timed out
rdat_o  output  32  read data, valid while any req_ack_o bit is high
en_o  output  1  register bus enable, one-cycle pulse per transaction
wr_o  output  1  register bus write
adr_o  output  28  register bus address
dat_o  output  32  register bus write data
dat_i  input  32  register bus read data (combinational from adr_o)
ack_i  input  1  register bus ack (one cycle after en_o)
err_count_o  output  16  saturating count of timeouts since reset

Behaviour:
- rst asserted (any time): state IDLE; req_ack_o, req_err_o, en_o, wr_o = 0; adr_o, dat_o, rdat_o = 0; timeout counter 0; err_count_o 0; grant pointer = NREQ-1 (so requester 0 wins first). An in-flight transaction is dropped with no ack.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_en_i bit is set, grant the first set bit searching upward from pointer+1 (mod NREQ). Latch its wr/adr/dat into wr_o/adr_o/dat_o, update the pointer to the grantee, go to ISSUE. With no request, stay in IDLE.
- ISSUE: en_o = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: en_o = 0; wr_o, adr_o, dat_o held.
  - If ack_i: capture dat_i into rdat_o (captured on writes too), req_err_o = 0, go to DONE.
  - Else if the counter has reached TIMEOUT-1: rdat_o = ERR_DATA, req_err_o = 1, err_count_o increments (saturating at 16'hFFFF), go to DONE.
  - Else increment the counter.
  - ack_i and the timeout in the same cycle: the ack wins, no error.
- DONE: req_ack_o[grant] = 1 for this cycle only, req_err_o as set in WAIT, rdat_o valid; go to IDLE. req_ack_o and req_err_o clear on leaving DONE.
- Timing: ack_i outside WAIT is ignored. Request changes after the grant do not affect the latched transaction.
- Nominal latency with a one-cycle-ack slave: request seen in IDLE at cycle 0, en_o at 1, ack_i at 2, req_ack_o at 3, next grant decision at 4.
- Fairness: a requester that holds req_en_i continuously gets every other grant when NREQ=2 and both request.

Test Plan:
- Single read, NREQ=2: req0 reads adr 2, slave returns 32'h12345678 with ack one cycle after en_o -> en_o pulses once with adr_o=2; req_ack_o=2'b01 exactly 3 cycles after the request is sampled; rdat_o=32'h12345678; req_err_o=0.
- Contention: req0 and req1 both held for 4 transactions from reset -> grant order 0,1,0,1; each req_ack_o a single-cycle one-hot pulse; no two en_o pulses closer than 4 cycles.
- Timeout: slave never acks, TIMEOUT=16 -> req_ack_o pulses 16 WAIT cycles after en_o with req_err_o=1, rdat_o=32'hDEADBEEF, err_count_o=1; the next request completes normally.
- Ack coincides with the final timeout cycle -> normal completion, req_err_o=0, err_count_o unchanged.
- Reset during WAIT: assert rst asynchronously mid-transaction -> all outputs 0 immediately; no req_ack_o; after release, requester 0 is granted first.
- Write pass-through: req1 writes 32'hCAFEF00D to adr 2 -> wr_o=1, dat_o=32'hCAFEF00D, adr_o=2 stable from ISSUE through WAIT; a later read of adr 2 returns 32'hCAFEF00D.
